// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, holds the IR
// for decode under a valid/ready handshake, and parks on the halt word.
module fetch_unit #(
  localparam int WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_SIZE-1:0] HALT_WORD = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WORD_SIZE-1:0] pointer,
  input  logic [WORD_SIZE-1:0] instr_in,
  input  logic                 branch_en,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  output logic                 halted
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e               state, state_nxt;
  logic [WORD_SIZE-1:0] pc_p0, pc_nxt;
  logic [WORD_SIZE-1:0] ir_p1, ir_nxt;
  logic [WORD_SIZE-1:0] ir_pc_p1, ir_pc_nxt;
  logic                 vld_p1, vld_nxt;
  logic                 advance;
  logic                 xfer;

  // Sequential increment; rolls over from all-ones to zero silently.
  function automatic logic [WORD_SIZE-1:0] pc_inc(input logic [WORD_SIZE-1:0] pc);
    return pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  endfunction

  assign advance = (state == RUN) && (!vld_p1 || instr_ready);
  assign xfer    = vld_p1 && instr_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    ir_nxt    = ir_p1;
    ir_pc_nxt = ir_pc_p1;
    vld_nxt   = vld_p1;
    unique case (state)
      RUN: begin
        if (branch_en) begin
          // Redirect drops whatever sits in the IR, even if decode is stalled.
          pc_nxt  = branch_target;
          vld_nxt = 1'b0;
        end else if (advance) begin
          if (instr_in == HALT_WORD) begin
            vld_nxt   = 1'b0;
            state_nxt = HALTED;
          end else begin
            ir_nxt    = instr_in;
            ir_pc_nxt = pc_p0;
            vld_nxt   = 1'b1;
            pc_nxt    = pc_inc(pc_p0);
          end
        end
      end
      HALTED: begin
        if (xfer) vld_nxt = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
  end

  // PC / IR stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc_p0    <= RESET_PC;
      ir_p1    <= '0;
      ir_pc_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_p0    <= pc_nxt;
      ir_p1    <= ir_nxt;
      ir_pc_p1 <= ir_pc_nxt;
      vld_p1   <= vld_nxt;
    end
  end

  assign pointer     = pc_p0;
  assign instr_out   = ir_p1;
  assign instr_pc    = ir_pc_p1;
  assign instr_valid = vld_p1;
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, backpressure, branch,
// halt, PC wrap (second instance) and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        instr_ready;

  logic [15:0] pointer, instr_in, instr_out, instr_pc;
  logic        instr_valid, halted;
  logic [15:0] pointer_w, instr_in_w, instr_out_w, instr_pc_w;
  logic        instr_valid_w, halted_w;

  logic [15:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instr_in   = mem[pointer[7:0]];
  assign instr_in_w = mem[pointer_w[7:0]];

  fetch_unit dut (
    .clk(clk), .rst(rst), .pointer(pointer), .instr_in(instr_in),
    .branch_en(branch_en), .branch_target(branch_target),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .pointer(pointer_w), .instr_in(instr_in_w),
    .branch_en(branch_en), .branch_target(branch_target),
    .instr_ready(instr_ready), .instr_out(instr_out_w), .instr_pc(instr_pc_w),
    .instr_valid(instr_valid_w), .halted(halted_w)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic [15:0] out, input logic [15:0] pc,
                        input logic vld, input logic [15:0] ptr);
    chk({tag, "_out"}, instr_out, out);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_vld"}, {15'd0, instr_valid}, {15'd0, vld});
    chk({tag, "_ptr"}, pointer, ptr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hE304; mem[1] = 16'hF300; mem[2] = 16'hE401; mem[3] = 16'hF400;
    for (int i = 4; i <= 18; i++) mem[i] = 16'hA000 | 16'(i);
    mem[19]  = 16'h0000;
    mem[255] = 16'hBEEF;

    rst = 1'b1; branch_en = 1'b0; branch_target = 16'h0000; instr_ready = 1'b1;
    step(); step();
    chk_ir("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    chk("reset_halted", {15'd0, halted}, 16'h0000);
    chk("reset_wrap_ptr", pointer_w, 16'hFFFF);

    // Straight-line fetch; the wrap instance runs alongside
    rst = 1'b0;
    step();
    chk_ir("s0", 16'hE304, 16'h0000, 1'b1, 16'h0001);
    chk("wrap0_pc", instr_pc_w, 16'hFFFF);
    chk("wrap0_out", instr_out_w, 16'hBEEF);
    step();
    chk_ir("s1", 16'hF300, 16'h0001, 1'b1, 16'h0002);
    chk("wrap1_pc", instr_pc_w, 16'h0000);
    chk("wrap1_out", instr_out_w, 16'hE304);

    // Backpressure for three cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ir("stall", 16'hF300, 16'h0001, 1'b1, 16'h0002);
    end
    instr_ready = 1'b1;
    step();
    chk_ir("s2", 16'hE401, 16'h0002, 1'b1, 16'h0003);
    step();
    chk_ir("s3", 16'hF400, 16'h0003, 1'b1, 16'h0004);
    for (int i = 4; i <= 9; i++) begin
      step();
      chk_ir("run", 16'hA000 | 16'(i), 16'(i), 1'b1, 16'(i + 1));
    end

    // Branch at PC=0x0A while decode stalls: branch wins
    branch_en = 1'b1; branch_target = 16'h0006; instr_ready = 1'b0;
    step();
    chk_ir("br", 16'hA009, 16'h0009, 1'b0, 16'h0006);
    branch_en = 1'b0; instr_ready = 1'b1;
    for (int i = 6; i <= 18; i++) begin
      step();
      chk_ir("post_br", 16'hA000 | 16'(i), 16'(i), 1'b1, 16'(i + 1));
    end

    // Halt word at address 19
    step();
    chk_ir("halt", 16'hA012, 16'h0012, 1'b0, 16'h0013);
    chk("halt_flag", {15'd0, halted}, 16'h0001);
    branch_en = 1'b1; branch_target = 16'h0003;
    step(); step();
    chk_ir("halt_br", 16'hA012, 16'h0012, 1'b0, 16'h0013);
    chk("halt_flag2", {15'd0, halted}, 16'h0001);
    branch_en = 1'b0;

    // Asynchronous reset out of HALTED, mid-cycle
    #2 rst = 1'b1;
    #1;
    chk_ir("areset_h", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    chk("areset_h_halted", {15'd0, halted}, 16'h0000);
    step();
    rst = 1'b0;
    step();
    chk_ir("r0", 16'hE304, 16'h0000, 1'b1, 16'h0001);
    step();
    instr_ready = 1'b0;
    step();
    chk_ir("r_stall", 16'hF300, 16'h0001, 1'b1, 16'h0002);

    // Asynchronous reset while stalled, mid-cycle
    #2 rst = 1'b1;
    #1;
    chk_ir("areset_s", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    step();
    rst = 1'b0; instr_ready = 1'b1;
    step();
    chk_ir("r2", 16'hE304, 16'h0000, 1'b1, 16'h0001);
    step();
    chk_ir("r3", 16'hF300, 16'h0001, 1'b1, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
